// File: rtl/mem_swap_pkg.sv
// Purpose: shared state encodings and datapath step codes for the memory-swap arbiter.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package mem_swap_pkg;

  // FSM state encodings (3 bits, kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_STEP1 = 3'd1;
  localparam logic [2:0] ST_STEP2 = 3'd2;
  localparam logic [2:0] ST_STEP3 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Datapath step selects
  localparam logic [1:0] SEL_IDLE = 2'b00;  // no transfer
  localparam logic [1:0] SEL_A2T  = 2'b01;  // mem[A] -> tmp
  localparam logic [1:0] SEL_B2A  = 2'b10;  // mem[B] -> mem[A]
  localparam logic [1:0] SEL_T2B  = 2'b11;  // tmp    -> mem[B]

  // Map a state to the datapath step it drives; IDLE/DONE leave the datapath quiet.
  function automatic logic [1:0] step_sel(input logic [2:0] st);
    logic [1:0] s;
    s = SEL_IDLE;
    case (st)
      ST_STEP1: s = SEL_A2T;
      ST_STEP2: s = SEL_B2A;
      ST_STEP3: s = SEL_T2B;
      default:  s = SEL_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_swap_rr_arb.sv
// Purpose: combinational round-robin pick among pending requesters, search starts at ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the parent decides when a grant is taken and advances ptr.
module mem_swap_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               vld,
  output logic [ID_W-1:0]    gnt
);

  logic [ID_W-1:0] idx;

  // Walk offsets from the far end back to zero so the nearest pending index to ptr wins.
  always_comb begin
    vld = |req;
    gnt = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt = idx;
      end
    end
  end

endmodule

// File: rtl/mem_swap_arbiter.sv
// Purpose: round-robin share of one 3-step memory swap datapath; `MEM_SWAP_COUNT_EN adds swap_count.
// Latency: grant edge -> ack 4 cycles later (1 cycle when both addresses match); one swap per 5 cycles.
// Backpressure: level req held until ack; no grant while busy, losers simply wait in req.
module mem_swap_arbiter
  import mem_swap_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4
`ifdef MEM_SWAP_COUNT_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_a,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_b,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic [ADDR_W-1:0]           addr_a,
  output logic [ADDR_W-1:0]           addr_b,
  output logic [1:0]                  sel,
  output logic                        w
`ifdef MEM_SWAP_COUNT_EN
  ,
  output logic [CNT_W-1:0]            swap_count
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [2:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_nxt;
  logic              arb_vld;
  logic [ID_W-1:0]   arb_gnt;
  logic [ADDR_W-1:0] slice_a [NUM_REQ];
  logic [ADDR_W-1:0] slice_b [NUM_REQ];
  logic              same_addr;

  mem_swap_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arb (
    .req (req),
    .ptr (rr_ptr),
    .vld (arb_vld),
    .gnt (arb_gnt)
  );

  // Unpack the per-requester address buses into indexable slices
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slice_a[i] = req_addr_a[i*ADDR_W +: ADDR_W];
      slice_b[i] = req_addr_b[i*ADDR_W +: ADDR_W];
    end
  end

  // Winner's address pair and the pointer position just past the winner
  always_comb begin
    same_addr  = (slice_a[arb_gnt] == slice_b[arb_gnt]);
    rr_ptr_nxt = (arb_gnt == ID_W'(NUM_REQ - 1)) ? '0 : arb_gnt + 1'b1;
  end

  // Sequencer: grant and latch in IDLE, then walk the fixed swap steps.
  // A swap of a location with itself is a no-op, so it jumps straight to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      addr_a <= '0;
      addr_b <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt_id <= arb_gnt;
            addr_a <= slice_a[arb_gnt];
            addr_b <= slice_b[arb_gnt];
            rr_ptr <= rr_ptr_nxt;
            state  <= same_addr ? ST_DONE : ST_STEP1;
          end
        end
        ST_STEP1: state <= ST_STEP2;
        ST_STEP2: state <= ST_STEP3;
        ST_STEP3: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode only from registered state and latches; req has no path to them
  always_comb begin
    sel  = step_sel(state);
    w    = (sel != SEL_IDLE);
    busy = (state != ST_IDLE);
    ack  = '0;
    if (state == ST_DONE) begin
      ack[gnt_id] = 1'b1;
    end
  end

`ifdef MEM_SWAP_COUNT_EN
  // Count every completion, including same-address skips; wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      swap_count <= '0;
    end else if (state == ST_DONE) begin
      swap_count <= swap_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_swap_arbiter.sv
// Purpose: self-checking bench for mem_swap_arbiter against a schedule-queue reference model.
// Latency: model predicts every output each cycle; directed cases pin the key latencies.
// Backpressure: requesters are driven directly; waits are bounded by cycle budgets.
module tb_mem_swap_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 4;
  localparam int ID_W    = 2;
  localparam int DONE_C  = 4;
`ifdef MEM_SWAP_COUNT_EN
  localparam int CNT_W   = 2;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_a;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_b;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic [ID_W-1:0]           gnt_id;
  logic [ADDR_W-1:0]         addr_a;
  logic [ADDR_W-1:0]         addr_b;
  logic [1:0]                sel;
  logic                      w;
`ifdef MEM_SWAP_COUNT_EN
  logic [CNT_W-1:0]          swap_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of upcoming step codes (1..3 = swap steps, 4 = done)
  int              m_sched[$];
  int              m_ptr;
  int              m_gnt;
  logic [ADDR_W-1:0] m_a;
  logic [ADDR_W-1:0] m_b;
  int              m_count;

  always #5 clk = ~clk;

  mem_swap_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W)
`ifdef MEM_SWAP_COUNT_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .ack        (ack),
    .busy       (busy),
    .gnt_id     (gnt_id),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .sel        (sel),
    .w          (w)
`ifdef MEM_SWAP_COUNT_EN
    ,
    .swap_count (swap_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_slice(input int i, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    req_addr_a[i*ADDR_W +: ADDR_W] = a;
    req_addr_b[i*ADDR_W +: ADDR_W] = b;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge
  task automatic model_edge();
    int g;
    g = -1;
    if (reset) begin
      m_sched.delete();
      m_ptr   = 0;
      m_gnt   = 0;
      m_a     = '0;
      m_b     = '0;
      m_count = 0;
    end else if (m_sched.size() > 0) begin
`ifdef MEM_SWAP_COUNT_EN
      if (m_sched[0] == DONE_C) m_count = (m_count + 1) % (1 << CNT_W);
`endif
      void'(m_sched.pop_front());
    end else if (req != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && ((req >> idx) & 4'b1) != 4'b0) g = idx;
      end
      m_gnt = g;
      m_a   = ADDR_W'(req_addr_a >> (g * ADDR_W));
      m_b   = ADDR_W'(req_addr_b >> (g * ADDR_W));
      m_ptr = (g + 1) % NUM_REQ;
      if (m_a == m_b) m_sched = '{DONE_C};
      else            m_sched = '{1, 2, 3, DONE_C};
    end
  endtask

  task automatic compare_all();
    int code;
    logic [NUM_REQ-1:0] exp_ack;
    code    = (m_sched.size() > 0) ? m_sched[0] : 0;
    exp_ack = (code == DONE_C) ? (4'b0001 << m_gnt) : 4'b0000;
    check_eq("sel",    32'(sel),    (code >= 1 && code <= 3) ? 32'(code) : 32'd0);
    check_eq("w",      32'(w),      (code >= 1 && code <= 3) ? 32'd1 : 32'd0);
    check_eq("busy",   32'(busy),   (code != 0) ? 32'd1 : 32'd0);
    check_eq("ack",    32'(ack),    32'(exp_ack));
    check_eq("gnt_id", 32'(gnt_id), 32'(m_gnt));
    check_eq("addr_a", 32'(addr_a), 32'(m_a));
    check_eq("addr_b", 32'(addr_b), 32'(m_b));
`ifdef MEM_SWAP_COUNT_EN
    check_eq("swap_count", 32'(swap_count), 32'(m_count));
`endif
  endtask

  // One clock: model steps at the edge, DUT is sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drain();
    int n;
    n = 0;
    req = '0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check_eq("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int ack_ids[$];
    int ack_t[$];
    logic [NUM_REQ-1:0] prev_ack;
    logic [NUM_REQ-1:0] cur_ack;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    req        = '0;
    req_addr_a = '0;
    req_addr_b = '0;
    do_reset();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sel",  32'(sel),  32'd0);

    // Single full swap from requester 0
    set_slice(0, 4'd3, 4'd9);
    req = 4'b0001;
    tick();
    check_eq("t1_c1_sel", 32'(sel), 32'd1);
    check_eq("t1_c1_addr_a", 32'(addr_a), 32'd3);
    check_eq("t1_c1_addr_b", 32'(addr_b), 32'd9);
    tick();
    check_eq("t1_c2_sel", 32'(sel), 32'd2);
    tick();
    check_eq("t1_c3_sel", 32'(sel), 32'd3);
    check_eq("t1_c3_w",   32'(w),   32'd1);
    tick();
    check_eq("t1_c4_ack",  32'(ack),  32'b0001);
    check_eq("t1_c4_busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    check_eq("t1_c5_busy", 32'(busy), 32'd0);

    // All four requesting continuously, each drops for one cycle after its ack
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_slice(i, ADDR_W'(i), ADDR_W'(i + 8));
    req      = 4'b1111;
    prev_ack = '0;
    for (int t = 1; t <= 26; t++) begin
      tick();
      cur_ack = ack;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (((cur_ack >> j) & 4'b1) != 4'b0) begin
          ack_ids.push_back(j);
          ack_t.push_back(t);
        end
      end
      req      = 4'b1111 & ~prev_ack;
      prev_ack = cur_ack;
    end
    drain();
    check_eq("rr_ack_count", 32'(ack_ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < ack_ids.size(); i++) begin
      check_eq("rr_order", 32'(ack_ids[i]), 32'(exp_order[i]));
      if (i > 0) check_eq("rr_gap", 32'(ack_t[i] - ack_t[i-1]), 32'd5);
    end

    // Same-address skip: ack right after grant, datapath never touched
    set_slice(2, 4'd7, 4'd7);
    req = 4'b0100;
    tick();
    check_eq("skip_ack", 32'(ack), 32'b0100);
    check_eq("skip_w",   32'(w),   32'd0);
    check_eq("skip_sel", 32'(sel), 32'd0);
    req = '0;
    tick();

    // Withdrawal and address change after grant do not disturb the swap
    set_slice(1, 4'd2, 4'd5);
    req = 4'b0010;
    tick();
    req = '0;
    set_slice(1, 4'd6, 4'd6);
    tick();
    tick();
    check_eq("wd_addr_a", 32'(addr_a), 32'd2);
    check_eq("wd_addr_b", 32'(addr_b), 32'd5);
    tick();
    check_eq("wd_ack", 32'(ack), 32'b0010);
    tick();

    // Reset during STEP2 aborts silently and clears the round-robin pointer
    set_slice(3, 4'd1, 4'd4);
    req = 4'b1000;
    tick();
    tick();
    check_eq("rst_mid_sel_pre", 32'(sel), 32'd2);
    reset = 1'b1;
    req   = '0;
    tick();
    check_eq("rst_mid_sel",  32'(sel),  32'd0);
    check_eq("rst_mid_w",    32'(w),    32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_ack",  32'(ack),  32'd0);
    reset = 1'b0;
    set_slice(0, 4'd10, 4'd11);
    req = 4'b1001;
    tick();
    check_eq("rst_mid_gnt", 32'(gnt_id), 32'd0);
    drain();

`ifdef MEM_SWAP_COUNT_EN
    begin
      int exp_cnt[5];
      exp_cnt = '{1, 2, 3, 0, 1};
      do_reset();
      check_eq("cnt_rst", 32'(swap_count), 32'd0);
      for (int s = 0; s < 5; s++) begin
        set_slice(0, 4'd4, (s == 2) ? 4'd4 : 4'd12);
        req = 4'b0001;
        tick();
        drain();
        check_eq("cnt_seq", 32'(swap_count), 32'(exp_cnt[s]));
      end
      do_reset();
      check_eq("cnt_clear", 32'(swap_count), 32'd0);
    end
`endif

    // Randomized traffic with occasional resets; small address range makes equal pairs common
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NUM_REQ; i++)
          set_slice(i, ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3)));
      end
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
